// File: rtl/kbd_disp_io.sv
// Memory-mapped keyboard/display device for the 03F0-03F3 I/O window.
// It owns KBDR/KBSR/DDR/DSR, buffers keyboard bytes in a FIFO and passes
// display bytes out over a valid/ready link. It also returns read data to
// the MDR one cycle after the read strobe, with the same latency as Sram.
//
// Display FSM
//   state  | meaning
//   S_IDLE | no byte in flight, DSR[15]=1, a DDR write launches a byte
//   S_SEND | byte offered on disp_data/disp_valid until disp_ready
module kbd_disp_io #(
    parameter int KB_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mio_en,
    input  logic        i_rw,
    input  logic [1:0]  i_inmux_sel,
    input  logic        i_ld_kbsr,
    input  logic        i_ld_ddr,
    input  logic        i_ld_dsr,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_mem_out,
    output logic [15:0] o_mdr_in,
    input  logic [7:0]  i_kb_data,
    input  logic        i_kb_valid,
    output logic        o_kb_ready,
    output logic [7:0]  o_disp_data,
    output logic        o_disp_valid,
    input  logic        i_disp_ready,
    output logic        o_irq
);

    localparam int PW = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } disp_state_t;

    logic [7:0]    r_kb_mem [KB_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ie_kb;

    disp_state_t   r_disp_state;
    logic [7:0]    r_disp_data;
    logic          r_disp_valid;
    logic          r_ie_disp;
    logic          r_derr;

    logic [1:0]    r_sel_q;
    logic [15:0]   r_io_rdata;

    logic          w_empty;
    logic          w_full;
    logic          w_rd_stb;
    logic          w_push;
    logic          w_pop;
    logic          w_ld_kbsr;
    logic          w_ld_ddr;
    logic          w_ld_dsr;
    logic          w_disp_idle;
    logic [15:0]   w_kbdr;
    logic [15:0]   w_kbsr;
    logic [15:0]   w_dsr;
    logic [15:0]   w_sel_data;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(KB_DEPTH));
    assign w_rd_stb    = i_mio_en & ~i_rw;
    // Write strobes from the address controller only count during an access.
    assign w_ld_kbsr   = i_ld_kbsr & i_mio_en;
    assign w_ld_ddr    = i_ld_ddr  & i_mio_en;
    assign w_ld_dsr    = i_ld_dsr  & i_mio_en;
    assign w_push      = i_kb_valid & ~w_full;
    assign w_pop       = w_rd_stb & (i_inmux_sel == 2'b00) & ~w_empty;
    assign w_disp_idle = (r_disp_state == S_IDLE);

    // An empty FIFO reads as zero rather than a stale slot.
    assign w_kbdr = w_empty ? 16'h0000 : {8'h00, r_kb_mem[r_rd_ptr]};
    assign w_kbsr = {~w_empty, r_ie_kb, 14'b0};
    assign w_dsr  = {w_disp_idle, r_ie_disp, r_derr, 13'b0};

    assign o_kb_ready   = ~w_full;
    assign o_disp_data  = r_disp_data;
    assign o_disp_valid = r_disp_valid;
    assign o_irq        = (~w_empty & r_ie_kb) | (w_disp_idle & r_ie_disp);
    assign o_mdr_in     = (r_sel_q == 2'b11) ? i_mem_out : r_io_rdata;

    // Select the device register addressed by the read mux.
    always_comb begin
        w_sel_data = 16'h0000;
        case (i_inmux_sel)
            2'b00:   w_sel_data = w_kbdr;
            2'b01:   w_sel_data = w_kbsr;
            2'b10:   w_sel_data = w_dsr;
            default: w_sel_data = 16'h0000;
        endcase
    end

    // FIFO storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_kb_mem[r_wr_ptr] <= i_kb_data;
        end
    end

    // FIFO pointers, occupancy and keyboard interrupt enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ie_kb  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ld_kbsr) begin
                r_ie_kb <= i_wdata[14];
            end
        end
    end

    // Capture read data one cycle after the strobe; sel_q holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel_q    <= 2'b11;
            r_io_rdata <= 16'h0000;
        end else if (w_rd_stb) begin
            r_sel_q    <= i_inmux_sel;
            r_io_rdata <= w_sel_data;
        end
    end

    // Display FSM with DSR control bits; a DDR write while busy only flags derr.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_disp_state <= S_IDLE;
            r_disp_data  <= 8'h00;
            r_disp_valid <= 1'b0;
            r_ie_disp    <= 1'b0;
            r_derr       <= 1'b0;
        end else begin
            case (r_disp_state)
                S_IDLE: begin
                    if (w_ld_ddr) begin
                        r_disp_data  <= i_wdata[7:0];
                        r_disp_valid <= 1'b1;
                        r_disp_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_disp_valid && i_disp_ready) begin
                        r_disp_valid <= 1'b0;
                        r_disp_state <= S_IDLE;
                    end
                end
                default: begin
                    r_disp_valid <= 1'b0;
                    r_disp_state <= S_IDLE;
                end
            endcase
            if (w_ld_dsr) begin
                r_ie_disp <= i_wdata[14];
                if (i_wdata[13]) begin
                    r_derr <= 1'b0;
                end
            end
            if (w_ld_ddr && !w_disp_idle) begin
                r_derr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kbd_disp_io.sv
// Bench for kbd_disp_io: a behavioural model of the FIFO and display state
// predicts each read; expected read data is queued at the strobe and
// compared when mdr_in presents it on the following cycle.
module tb_kbd_disp_io;

    localparam int KB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mio_en;
    logic        rw;
    logic [1:0]  inmux_sel;
    logic        ld_kbsr;
    logic        ld_ddr;
    logic        ld_dsr;
    logic [15:0] wdata;
    logic [15:0] mem_out;
    logic [15:0] mdr_in;
    logic [7:0]  kb_data;
    logic        kb_valid;
    logic        kb_ready;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ready;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] sb_q [$];
    logic [7:0]  kb_model [$];
    bit          pend_pop;
    bit          m_ie_kb;
    bit          m_ie_disp;
    bit          m_derr;
    bit          m_idle;
    logic [7:0]  m_disp_data;

    kbd_disp_io #(.KB_DEPTH(KB_DEPTH)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mio_en     (mio_en),
        .i_rw         (rw),
        .i_inmux_sel  (inmux_sel),
        .i_ld_kbsr    (ld_kbsr),
        .i_ld_ddr     (ld_ddr),
        .i_ld_dsr     (ld_dsr),
        .i_wdata      (wdata),
        .i_mem_out    (mem_out),
        .o_mdr_in     (mdr_in),
        .i_kb_data    (kb_data),
        .i_kb_valid   (kb_valid),
        .o_kb_ready   (kb_ready),
        .o_disp_data  (disp_data),
        .o_disp_valid (disp_valid),
        .i_disp_ready (disp_ready),
        .o_irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock edge; the model advances from the inputs present before it.
    task automatic tick();
        bit         acc;
        logic [7:0] d;
        bit         n_idle;
        acc    = kb_valid && (kb_model.size() < KB_DEPTH);
        d      = kb_data;
        n_idle = m_idle;
        if (!rst) begin
            if (!m_idle && disp_ready) n_idle = 1'b1;
            if (mio_en && ld_ddr) begin
                if (m_idle) begin
                    n_idle      = 1'b0;
                    m_disp_data = wdata[7:0];
                end else begin
                    m_derr = 1'b1;
                end
            end
            if (mio_en && ld_kbsr) m_ie_kb = wdata[14];
            if (mio_en && ld_dsr) begin
                m_ie_disp = wdata[14];
                if (wdata[13]) m_derr = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            kb_model.delete();
            m_ie_kb     = 1'b0;
            m_ie_disp   = 1'b0;
            m_derr      = 1'b0;
            m_idle      = 1'b1;
            m_disp_data = 8'h00;
        end else begin
            if (pend_pop) void'(kb_model.pop_front());
            if (acc) kb_model.push_back(d);
            m_idle = n_idle;
        end
        pend_pop = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, input string tag);
        logic [15:0] e;
        case (sel)
            2'b00:   e = (kb_model.size() != 0) ? {8'h00, kb_model[0]} : 16'h0000;
            2'b01:   e = {(kb_model.size() != 0), m_ie_kb, 14'b0};
            2'b10:   e = {m_idle, m_ie_disp, m_derr, 13'b0};
            default: e = mem_out;
        endcase
        if (sel == 2'b00 && kb_model.size() != 0) pend_pop = 1'b1;
        sb_q.push_back(e);
        mio_en    = 1'b1;
        rw        = 1'b0;
        inmux_sel = sel;
        tick();
        mio_en    = 1'b0;
        check_val(tag, mdr_in, sb_q.pop_front());
    endtask

    // kind: 0 KBSR, 1 DDR, 2 DSR
    task automatic wr(input int kind, input logic [15:0] data);
        mio_en  = 1'b1;
        rw      = 1'b1;
        wdata   = data;
        ld_kbsr = (kind == 0);
        ld_ddr  = (kind == 1);
        ld_dsr  = (kind == 2);
        tick();
        mio_en  = 1'b0;
        rw      = 1'b0;
        ld_kbsr = 1'b0;
        ld_ddr  = 1'b0;
        ld_dsr  = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        kb_valid = 1'b1;
        kb_data  = b;
        tick();
        kb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mio_en = 1'b0; rw = 1'b0; inmux_sel = 2'b11;
        ld_kbsr = 1'b0; ld_ddr = 1'b0; ld_dsr = 1'b0; wdata = 16'h0000;
        mem_out = 16'hBEEF; kb_data = 8'h00; kb_valid = 1'b0; disp_ready = 1'b0;
        pend_pop = 1'b0; m_idle = 1'b1; m_ie_kb = 1'b0; m_ie_disp = 1'b0;
        m_derr = 1'b0; m_disp_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_mdr", mdr_in, 16'hBEEF);
        check_val("rst_kb_ready", {15'b0, kb_ready}, 16'h0001);
        check_val("rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
        check_val("rst_disp_data", {8'h00, disp_data}, 16'h0000);
        check_val("rst_irq", {15'b0, irq}, 16'h0000);
        rd(2'b10, "rst_dsr");
        check_val("dsr_rst_const", mdr_in, 16'h8000);
        rd(2'b11, "mem_sel");
        mem_out = 16'h1234;
        #1;
        check_val("mem_follow", mdr_in, 16'h1234);

        // Basic push / pop
        push(8'h41);
        push(8'h42);
        rd(2'b01, "kbsr_ready");
        check_val("kbsr_ready_const", mdr_in, 16'h8000);
        rd(2'b00, "kbdr_0");
        check_val("kbdr_0_const", mdr_in, 16'h0041);
        rd(2'b00, "kbdr_1");
        check_val("kbdr_1_const", mdr_in, 16'h0042);
        rd(2'b01, "kbsr_empty");
        rd(2'b00, "kbdr_empty");

        // Empty FIFO: push and KBDR read in the same cycle
        kb_valid = 1'b1; kb_data = 8'h5A;
        rd(2'b00, "kbdr_empty_push");
        kb_valid = 1'b0;
        rd(2'b00, "kbdr_after_empty_push");

        // Full FIFO
        for (int i = 0; i < KB_DEPTH; i++) push(8'h10 + 8'(i));
        check_val("full_kb_ready", {15'b0, kb_ready}, 16'h0000);
        push(8'h99);
        kb_valid = 1'b1; kb_data = 8'h20;
        rd(2'b00, "full_pop_nopush");
        kb_data = 8'h21;
        rd(2'b00, "pop_push");
        check_val("pop_push_ready", {15'b0, kb_ready}, 16'h0001);
        kb_data = 8'h22;
        tick();
        kb_valid = 1'b0;
        check_val("refill_kb_ready", {15'b0, kb_ready}, 16'h0000);
        for (int i = 0; i < KB_DEPTH; i++) rd(2'b00, "drain");
        rd(2'b01, "kbsr_drained");

        // Display transfer with back-pressure
        wr(1, 16'h1258);
        check_val("ddr_valid", {15'b0, disp_valid}, 16'h0001);
        check_val("ddr_data", {8'h00, disp_data}, 16'h0058);
        rd(2'b10, "dsr_busy");
        for (int i = 0; i < 5; i++) tick();
        check_val("hold_valid", {15'b0, disp_valid}, 16'h0001);
        check_val("hold_data", {8'h00, disp_data}, {8'h00, m_disp_data});
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        check_val("hs_valid", {15'b0, disp_valid}, 16'h0000);
        rd(2'b10, "dsr_idle");

        // Overrun while sending
        wr(1, 16'h00C3);
        wr(1, 16'h00A7);
        check_val("ovr_data", {8'h00, disp_data}, 16'h00C3);
        rd(2'b10, "dsr_derr");
        check_val("dsr_derr_const", mdr_in, 16'h2000);
        wr(2, 16'h2000);
        rd(2'b10, "dsr_derr_clr");
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        rd(2'b10, "dsr_idle2");

        // Strobe without mio_en is ignored
        ld_ddr = 1'b1; wdata = 16'h0077;
        tick();
        ld_ddr = 1'b0;
        check_val("ld_no_mio", {15'b0, disp_valid}, 16'h0000);

        // Interrupts
        wr(0, 16'h4000);
        rd(2'b01, "kbsr_ie");
        check_val("irq_ie_empty", {15'b0, irq}, 16'h0000);
        push(8'h0D);
        check_val("irq_kb", {15'b0, irq}, 16'h0001);
        rd(2'b00, "kbdr_cr");
        check_val("irq_kb_pop", {15'b0, irq}, 16'h0000);
        wr(2, 16'h4000);
        check_val("irq_disp", {15'b0, irq}, 16'h0001);
        wr(2, 16'h0000);

        // Reset mid-transfer
        wr(1, 16'h0033);
        push(8'h55);
        check_val("pre_rst_valid", {15'b0, disp_valid}, 16'h0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_mid_valid", {15'b0, disp_valid}, 16'h0000);
        check_val("rst_mid_irq", {15'b0, irq}, 16'h0000);
        rd(2'b00, "rst_fifo_flush");
        rd(2'b01, "rst_kbsr");

        if (sb_q.size() != 0) check_val("sb_leftover", 16'(sb_q.size()), 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
